// File: rtl/dp_bsr_mc_pkg.sv
// Shared types for the multi-channel boundary scan register: mode and chain-lock state encodings.
package dp_bsr_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        SAMPLE = 2'b01,
        EXTEST = 2'b10,
        CLAMP  = 2'b11
    } bsr_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CAP   = 2'b01,
        SHIFT = 2'b10
    } bsr_state_t;

    // Chain index width; a single chain still needs a 1-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dp_bsr_mc_if.sv
// TAP-side strobes, pin buses and status outputs of the boundary scan register.
interface dp_bsr_mc_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2
);
    import dp_bsr_pkg::*;

    localparam int CH_W  = ch_width(CHANNELS);
    localparam int CNT_W = $clog2(WIDTH + 1) + 1;

    logic                      tck_en;
    logic                      capture_dr;
    logic                      shift_dr;
    logic                      update_dr;
    logic [CH_W-1:0]           chain_sel;
    logic [MODE_W-1:0]         mode;
    logic                      tdi;
    logic                      tdo;
    logic [CHANNELS*WIDTH-1:0] p_data_in;
    logic [CHANNELS*WIDTH-1:0] p_data_out;
    logic                      seq_err;
    logic [CNT_W-1:0]          shift_cnt;
    logic                      len_err;

    modport master (
        output tck_en, capture_dr, shift_dr, update_dr, chain_sel, mode, tdi, p_data_in,
        input  tdo, p_data_out, seq_err, shift_cnt, len_err
    );

    modport slave (
        input  tck_en, capture_dr, shift_dr, update_dr, chain_sel, mode, tdi, p_data_in,
        output tdo, p_data_out, seq_err, shift_cnt, len_err
    );

endinterface

// File: rtl/dp_bsr_mc_chain.sv
// One boundary scan chain: WIDTH-bit capture/shift register plus its parallel update register.
module dp_bsr_chain #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             cap_en_i,
    input  logic             shift_en_i,
    input  logic             upd_en_i,
    input  logic [WIDTH-1:0] cap_data_i,
    input  logic             tdi_i,
    output logic [WIDTH-1:0] sr_o,
    output logic [WIDTH-1:0] ur_o
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] ur_q, ur_d;

    always_comb begin
        sr_d = sr_q;
        ur_d = ur_q;
        if (cap_en_i) begin
            sr_d = cap_data_i;
        end else if (shift_en_i) begin
            // LSB leaves on tdo, tdi enters at the MSB.
            sr_d = {tdi_i, sr_q[WIDTH-1:1]};
        end
        if (upd_en_i) begin
            ur_d = sr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sr_q <= '0;
            ur_q <= '0;
        end else begin
            sr_q <= sr_d;
            ur_q <= ur_d;
        end
    end

    assign sr_o = sr_q;
    assign ur_o = ur_q;

endmodule

// File: rtl/dp_bsr_mc.sv
// Multi-channel boundary scan register: chain-lock FSM, tdo/output muxing, optional shift-length
// checking enabled by defining DP_BSR_SHIFT_CNT_EN.
module dp_bsr_mc
    import dp_bsr_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               CHANNELS = 2,
    parameter logic [WIDTH-1:0] SAFE_VAL = '0
) (
    input logic          iclk,
    input logic          reset,
    dp_bsr_mc_if.slave   bus
);

    localparam int CH_W  = ch_width(CHANNELS);
    localparam int CNT_W = $clog2(WIDTH + 1) + 1;

    bsr_state_t      state_q, state_d;
    logic [CH_W-1:0] locked_q, locked_d;
    logic            seq_err_q, seq_err_d;
    logic [CH_W-1:0] sel_clamped;
    logic            sel_oob;
    logic            multi_strobe;
    logic            do_cap, do_upd, do_shift;
    bsr_mode_t       mode_e;

    logic [CHANNELS-1:0] cap_en, shift_en, upd_en;
    logic [WIDTH-1:0]    sr_w [CHANNELS];
    logic [WIDTH-1:0]    ur_w [CHANNELS];

    assign mode_e       = bsr_mode_t'(bus.mode);
    assign sel_oob      = (32'(bus.chain_sel) >= 32'(CHANNELS));
    assign sel_clamped  = sel_oob ? CH_W'(CHANNELS - 1) : bus.chain_sel;
    assign multi_strobe = (bus.capture_dr & bus.update_dr) | (bus.capture_dr & bus.shift_dr) |
                          (bus.update_dr & bus.shift_dr);

    // Strobe priority is capture > update > shift; only the winner touches any register.
    always_comb begin
        state_d   = state_q;
        locked_d  = locked_q;
        seq_err_d = 1'b0;
        do_cap    = 1'b0;
        do_upd    = 1'b0;
        do_shift  = 1'b0;
        if (bus.tck_en) begin
            if (multi_strobe) seq_err_d = 1'b1;
            if (bus.capture_dr) begin
                do_cap   = 1'b1;
                state_d  = CAP;
                locked_d = sel_clamped;
                if (sel_oob) seq_err_d = 1'b1;
            end else if (bus.update_dr) begin
                if (state_q == IDLE) begin
                    seq_err_d = 1'b1;
                end else begin
                    do_upd  = 1'b1;
                    state_d = IDLE;
                end
            end else if (bus.shift_dr) begin
                if (state_q == IDLE) begin
                    seq_err_d = 1'b1;
                end else begin
                    do_shift = 1'b1;
                    state_d  = SHIFT;
                end
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (reset) begin
            state_q   <= IDLE;
            locked_q  <= '0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            locked_q  <= locked_d;
            seq_err_q <= seq_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] out_w;

            assign cap_en[gi]   = do_cap   && (sel_clamped == CH_W'(gi));
            assign shift_en[gi] = do_shift && (locked_q == CH_W'(gi));
            assign upd_en[gi]   = do_upd   && (locked_q == CH_W'(gi));

            dp_bsr_chain #(.WIDTH(WIDTH)) u_chain (
                .clk_i      (iclk),
                .srst_i     (reset),
                .cap_en_i   (cap_en[gi]),
                .shift_en_i (shift_en[gi]),
                .upd_en_i   (upd_en[gi]),
                .cap_data_i (bus.p_data_in[gi*WIDTH +: WIDTH]),
                .tdi_i      (bus.tdi),
                .sr_o       (sr_w[gi]),
                .ur_o       (ur_w[gi])
            );

            always_comb begin
                out_w = bus.p_data_in[gi*WIDTH +: WIDTH];
                case (mode_e)
                    EXTEST:  out_w = ur_w[gi];
                    CLAMP:   out_w = SAFE_VAL;
                    default: out_w = bus.p_data_in[gi*WIDTH +: WIDTH];
                endcase
            end

            assign bus.p_data_out[gi*WIDTH +: WIDTH] = out_w;
        end
    endgenerate

    assign bus.tdo     = sr_w[locked_q][0];
    assign bus.seq_err = seq_err_q;

`ifdef DP_BSR_SHIFT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             len_err_q, len_err_d;

    // The counter saturates so an over-long shift still reads as a length error.
    always_comb begin
        cnt_d     = cnt_q;
        len_err_d = 1'b0;
        if (do_cap) begin
            cnt_d = '0;
        end else if (do_shift && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (do_upd && (cnt_q != CNT_W'(WIDTH))) begin
            len_err_d = 1'b1;
        end
    end

    always_ff @(posedge iclk) begin
        if (reset) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign bus.shift_cnt = cnt_q;
    assign bus.len_err   = len_err_q;
`else
    assign bus.shift_cnt = '0;
    assign bus.len_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dp_bsr_mc.sv
// Self-checking bench for dp_bsr_mc (WIDTH=8, CHANNELS=2, SAFE_VAL=0x3C); tdo expectations go
// through a scoreboard queue, other outputs are compared inline after each transaction.
module tb_dp_bsr_mc;
    import dp_bsr_pkg::*;

    localparam int W  = 8;
    localparam int CH = 2;
`ifdef DP_BSR_SHIFT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic iclk = 1'b0;
    logic reset;
    always #5 iclk = ~iclk;

    dp_bsr_mc_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    dp_bsr_mc #(.WIDTH(W), .CHANNELS(CH), .SAFE_VAL(8'h3C)) dut (
        .iclk  (iclk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    logic tdo_q[$];

    // One tck transaction: inputs applied after the previous edge, outputs valid #1 after this one.
    task automatic tick(input logic en, input logic cap, input logic sh, input logic upd,
                        input logic tdi_v);
        bus.tck_en     = en;
        bus.capture_dr = cap;
        bus.shift_dr   = sh;
        bus.update_dr  = upd;
        bus.tdi        = tdi_v;
        @(posedge iclk);
        #1;
        bus.tck_en     = 1'b0;
        bus.capture_dr = 1'b0;
        bus.shift_dr   = 1'b0;
        bus.update_dr  = 1'b0;
        $display("[%0t] tck_en=%b cap=%b shift=%b upd=%b tdi=%b sel=%0d mode=%0d -> tdo=%b seq_err=%b p_out=%h cnt=%0d len_err=%b",
                 $time, en, cap, sh, upd, tdi_v, bus.chain_sel, bus.mode, bus.tdo, bus.seq_err,
                 bus.p_data_out, bus.shift_cnt, bus.len_err);
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.tck_en     = 1'b0;
        bus.capture_dr = 1'b0;
        bus.shift_dr   = 1'b0;
        bus.update_dr  = 1'b0;
        bus.tdi        = 1'b0;
        bus.chain_sel  = '0;
        bus.mode       = NORMAL;
        bus.p_data_in  = 16'hA596;
        repeat (3) @(posedge iclk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.tdo !== 1'b0) begin
            errors++; $display("FAIL reset_tdo: got %b expected 0", bus.tdo);
        end
        checks++;
        if (bus.seq_err !== 1'b0) begin
            errors++; $display("FAIL reset_seq_err: got %b expected 0", bus.seq_err);
        end
        checks++;
        if (bus.p_data_out !== 16'hA596) begin
            errors++; $display("FAIL reset_p_out: got %h expected a596", bus.p_data_out);
        end
        checks++;
        if (bus.shift_cnt !== '0 || bus.len_err !== 1'b0) begin
            errors++; $display("FAIL reset_cnt: got cnt=%0d len_err=%b expected 0/0", bus.shift_cnt, bus.len_err);
        end
    endtask

    task automatic test_capture_shift();
        logic [7:0] cap_v;
        logic       exp;
        cap_v = 8'hA5;
        for (int i = 0; i < 8; i++) tdo_q.push_back(cap_v[i]);
        tdo_q.push_back(1'b1);
        bus.chain_sel = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp = tdo_q.pop_front();
        checks++;
        if (bus.tdo !== exp) begin
            errors++; $display("FAIL cap_tdo: got %b expected %b", bus.tdo, exp);
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            exp = tdo_q.pop_front();
            checks++;
            if (bus.tdo !== exp) begin
                errors++; $display("FAIL shift_tdo[%0d]: got %b expected %b", k, bus.tdo, exp);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.p_data_out !== 16'hA596) begin
            errors++; $display("FAIL normal_p_out: got %h expected a596", bus.p_data_out);
        end
        bus.mode = EXTEST;
        @(posedge iclk);
        #1;
        checks++;
        if (bus.p_data_out !== 16'hFF00) begin
            errors++; $display("FAIL extest_p_out: got %h expected ff00", bus.p_data_out);
        end
    endtask

    task automatic test_sel_lock();
        logic [7:0] cap_v;
        logic [7:0] pat;
        logic       exp;
        cap_v = 8'h96;
        pat   = 8'h53;
        bus.chain_sel = 1'b0;
        tdo_q.push_back(cap_v[0]);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp = tdo_q.pop_front();
        checks++;
        if (bus.tdo !== exp) begin
            errors++; $display("FAIL lock_cap_tdo: got %b expected %b", bus.tdo, exp);
        end
        bus.chain_sel = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tdo_q.push_back((k < 7) ? cap_v[k+1] : pat[0]);
            tick(1'b1, 1'b0, 1'b1, 1'b0, pat[k]);
            exp = tdo_q.pop_front();
            checks++;
            if (bus.tdo !== exp) begin
                errors++; $display("FAIL lock_shift_tdo[%0d]: got %b expected %b", k, bus.tdo, exp);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.p_data_out !== 16'hFF53) begin
            errors++; $display("FAIL lock_update: got %h expected ff53", bus.p_data_out);
        end
    endtask

    task automatic test_collision();
        bus.chain_sel = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.chain_sel = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.seq_err !== 1'b1) begin
            errors++; $display("FAIL collide_seq_err: got %b expected 1", bus.seq_err);
        end
        checks++;
        if (bus.tdo !== 1'b1) begin
            errors++; $display("FAIL collide_tdo: got %b expected 1", bus.tdo);
        end
        checks++;
        if (bus.p_data_out !== 16'hFF53) begin
            errors++; $display("FAIL collide_ur: got %h expected ff53", bus.p_data_out);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.seq_err !== 1'b0) begin
            errors++; $display("FAIL collide_seq_err_pulse: got %b expected 0", bus.seq_err);
        end
    endtask

    task automatic test_tck_gating();
        logic exp;
        for (int k = 0; k < 5; k++) begin
            tdo_q.push_back(1'b1);
            tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            exp = tdo_q.pop_front();
            checks++;
            if (bus.tdo !== exp) begin
                errors++; $display("FAIL gated_tdo[%0d]: got %b expected %b", k, bus.tdo, exp);
            end
        end
        checks++;
        if (bus.shift_cnt !== '0) begin
            errors++; $display("FAIL gated_cnt: got %0d expected 0", bus.shift_cnt);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.p_data_out !== 16'hA553) begin
            errors++; $display("FAIL gated_update: got %h expected a553", bus.p_data_out);
        end
        checks++;
        if (bus.len_err !== CNT_EN) begin
            errors++; $display("FAIL gated_len_err: got %b expected %b", bus.len_err, CNT_EN);
        end
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.seq_err !== 1'b1) begin
            errors++; $display("FAIL idle_shift_seq_err: got %b expected 1", bus.seq_err);
        end
        checks++;
        if (bus.tdo !== 1'b1 || bus.p_data_out !== 16'hA553) begin
            errors++; $display("FAIL idle_shift_hold: got tdo=%b p_out=%h expected 1/a553", bus.tdo, bus.p_data_out);
        end
    endtask

    task automatic test_clamp();
        bus.mode = CLAMP;
        @(posedge iclk);
        #1;
        checks++;
        if (bus.p_data_out !== 16'h3C3C) begin
            errors++; $display("FAIL clamp_p_out: got %h expected 3c3c", bus.p_data_out);
        end
        bus.mode      = NORMAL;
        bus.p_data_in = 16'h1234;
        @(posedge iclk);
        #1;
        checks++;
        if (bus.p_data_out !== 16'h1234) begin
            errors++; $display("FAIL unclamp_p_out: got %h expected 1234", bus.p_data_out);
        end
    endtask

    task automatic test_cnt_reset();
        logic [4:0] exp_cnt;
        exp_cnt = CNT_EN ? 5'd7 : 5'd0;
        bus.mode      = EXTEST;
        bus.chain_sel = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.shift_cnt !== exp_cnt) begin
            errors++; $display("FAIL cnt_after_7: got %0d expected %0d", bus.shift_cnt, exp_cnt);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.len_err !== CNT_EN) begin
            errors++; $display("FAIL short_len_err: got %b expected %b", bus.len_err, CNT_EN);
        end
        checks++;
        if (bus.p_data_out !== 16'hA5FE) begin
            errors++; $display("FAIL short_update: got %h expected a5fe", bus.p_data_out);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.len_err !== 1'b0) begin
            errors++; $display("FAIL len_err_pulse: got %b expected 0", bus.len_err);
        end
        bus.chain_sel = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge iclk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.p_data_out !== 16'h0000 || bus.tdo !== 1'b0) begin
            errors++; $display("FAIL midreset_state: got p_out=%h tdo=%b expected 0000/0", bus.p_data_out, bus.tdo);
        end
        checks++;
        if (bus.shift_cnt !== '0) begin
            errors++; $display("FAIL midreset_cnt: got %0d expected 0", bus.shift_cnt);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.seq_err !== 1'b1 || bus.p_data_out !== 16'h0000) begin
            errors++; $display("FAIL midreset_idle: got seq_err=%b p_out=%h expected 1/0000", bus.seq_err, bus.p_data_out);
        end
    endtask

    initial begin
        test_reset();
        test_capture_shift();
        test_sel_lock();
        test_collision();
        test_tck_gating();
        test_clamp();
        test_cnt_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
